// File: rtl/letc_core_rf_if.sv
// letc_core_rf_if
//   Bundles the register-file traffic of the LETC core: the writeback
//   register-write port, the two decode read ports with their hazard flags,
//   and the scoreboard reservation/flush controls.
//   master : writeback + decode side (drives indices, data, reservations)
//   slave  : the register file (returns operands, busy flags, sb_err)
interface letc_core_rf_if;
  logic [4:0]  rf_rd_idx;
  logic [31:0] rf_rd_val;
  logic        rf_rd_we;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        sb_set;
  logic [4:0]  sb_set_idx;
  logic        sb_flush;
  logic        sb_err;

  modport master (
    output rf_rd_idx, rf_rd_val, rf_rd_we,
    output rs1_idx, rs2_idx,
    output sb_set, sb_set_idx, sb_flush,
    input  rs1_val, rs2_val, rs1_busy, rs2_busy, sb_err
  );

  modport slave (
    input  rf_rd_idx, rf_rd_val, rf_rd_we,
    input  rs1_idx, rs2_idx,
    input  sb_set, sb_set_idx, sb_flush,
    output rs1_val, rs2_val, rs1_busy, rs2_busy, sb_err
  );
endinterface

// File: rtl/letc_core_rf.sv
// letc_core_rf
//   Integer register file (x1..x31, x0 hardwired to zero) with write-through
//   bypass on both read ports, plus a per-register outstanding-writer
//   scoreboard built from saturating counters.
// Ports:
//   clk    : core clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset, clears registers, counters, sb_err
//   rf     : letc_core_rf_if.slave
//            rf_rd_idx/rf_rd_val/rf_rd_we : writeback register write
//            rs1_idx/rs2_idx              : decode read indices
//            rs1_val/rs2_val              : bypassed operand data
//            rs1_busy/rs2_busy            : outstanding writer not retiring now
//            sb_set/sb_set_idx            : reserve a destination register
//            sb_flush                     : drop every reservation
//            sb_err                       : sticky, reservation hit a full counter
module letc_core_rf #(
  parameter int SB_CNT_W = 3
) (
  input logic           clk,
  input logic           rst_n,
  letc_core_rf_if.slave rf
);

  localparam logic [SB_CNT_W-1:0] CNT_MAX = {SB_CNT_W{1'b1}};

  logic [31:0]         regs_q [1:31];
  logic [SB_CNT_W-1:0] cnt_q  [1:31];
  logic [SB_CNT_W-1:0] cnt_d  [1:31];
  logic                sb_err_q;
  logic                sb_err_d;

  // One-hot per-register increment/decrement requests; x0 never appears.
  logic [31:1] inc_vec;
  logic [31:1] dec_vec;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (rf.sb_set && (rf.sb_set_idx != 5'd0)) begin
      inc_vec[rf.sb_set_idx] = 1'b1;
    end
    if (rf.rf_rd_we && (rf.rf_rd_idx != 5'd0)) begin
      dec_vec[rf.rf_rd_idx] = 1'b1;
    end
  end

  // Counter next state. Flush wins over everything; a simultaneous
  // reservation and retirement on the same register cancel out.
  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 1; r <= 31; r++) begin
      cnt_d[r] = cnt_q[r];
      if (rf.sb_flush) begin
        cnt_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt_q[r] == CNT_MAX) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + SB_CNT_W'(1);
        end
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - SB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r <= 31; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 1; r <= 31; r++) begin
        cnt_q[r] <= cnt_d[r];
        if (dec_vec[r]) begin
          regs_q[r] <= rf.rf_rd_val;
        end
      end
      sb_err_q <= sb_err_d;
    end
  end

  // Read port 1: x0 reads zero, a same-cycle write is bypassed.
  // Busy only if writers remain after the one retiring this cycle.
  always_comb begin
    rf.rs1_val  = '0;
    rf.rs1_busy = 1'b0;
    if (rf.rs1_idx != 5'd0) begin
      if (dec_vec[rf.rs1_idx]) begin
        rf.rs1_val = rf.rf_rd_val;
      end else begin
        rf.rs1_val = regs_q[rf.rs1_idx];
      end
      rf.rs1_busy = (cnt_q[rf.rs1_idx] > SB_CNT_W'(dec_vec[rf.rs1_idx]));
    end
  end

  // Read port 2: identical rules to port 1.
  always_comb begin
    rf.rs2_val  = '0;
    rf.rs2_busy = 1'b0;
    if (rf.rs2_idx != 5'd0) begin
      if (dec_vec[rf.rs2_idx]) begin
        rf.rs2_val = rf.rf_rd_val;
      end else begin
        rf.rs2_val = regs_q[rf.rs2_idx];
      end
      rf.rs2_busy = (cnt_q[rf.rs2_idx] > SB_CNT_W'(dec_vec[rf.rs2_idx]));
    end
  end

  assign rf.sb_err = sb_err_q;

endmodule
